// File: rtl/pixel_plot_queue.sv
// Clip-and-queue stage between the Reuleaux drawer and the VGA adapter.
// On-screen plot requests are buffered in a FIFO and drained to the adapter under vga_ready.
module pixel_plot_queue #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       in_x,
    input  logic [6:0]       in_y,
    input  logic [2:0]       in_colour,
    input  logic             in_plot,
    output logic             in_ready,
    input  logic             draw_done,
    output logic [7:0]       vga_x,
    output logic [6:0]       vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot,
    input  logic             vga_ready,
    output logic             done,
    output logic [CNT_W-1:0] plotted_count,
    output logic [CNT_W-1:0] clipped_count,
    output logic             overflow
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [8:0]  X_LIM    = 9'(SCREEN_W);
    localparam logic [7:0]  Y_LIM    = 8'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [17:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [7:0]       r_vga_x;
    logic [6:0]       r_vga_y;
    logic [2:0]       r_vga_colour;
    logic             r_vga_plot;
    logic             r_done;
    logic [CNT_W-1:0] r_plotted;
    logic [CNT_W-1:0] r_clipped;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_clip;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_start_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Request classification and FIFO handshake decode
    always_comb begin
        w_full      = (r_count == FULL_CNT);
        w_empty     = (r_count == {(AW+1){1'b0}});
        w_accept    = in_plot && ((r_state == S_RUN) || (r_state == S_FLUSH));
        w_clip      = ({1'b0, in_x} >= X_LIM) || ({1'b0, in_y} >= Y_LIM);
        w_push      = w_accept && !w_clip && !w_full;
        w_drop      = w_accept && !w_clip && w_full;
        w_pop       = !w_empty && vga_ready;
        w_start_run = (r_state == S_IDLE) && start;
    end

    // FIFO storage; occupancy guards every read so the array needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_x, in_y, in_colour};
        end
    end

    // Pointers, output register, counters and draw sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= {AW{1'b0}};
            r_rd_ptr     <= {AW{1'b0}};
            r_count      <= {(AW+1){1'b0}};
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= 3'd0;
            r_vga_plot   <= 1'b0;
            r_done       <= 1'b0;
            r_plotted    <= {CNT_W{1'b0}};
            r_clipped    <= {CNT_W{1'b0}};
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                {r_vga_x, r_vga_y, r_vga_colour} <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_vga_plot <= w_pop;

            if (w_start_run) begin
                r_plotted  <= {CNT_W{1'b0}};
                r_clipped  <= {CNT_W{1'b0}};
                r_overflow <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_plotted <= sat_inc(r_plotted);
                end
                if (w_accept && w_clip) begin
                    r_clipped <= sat_inc(r_clipped);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end

            // A push into an empty FIFO during FLUSH still has to be drained before DONE
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (draw_done) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_empty && !w_push) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = !w_full;
    assign vga_x         = r_vga_x;
    assign vga_y         = r_vga_y;
    assign vga_colour    = r_vga_colour;
    assign vga_plot      = r_vga_plot;
    assign done          = r_done;
    assign plotted_count = r_plotted;
    assign clipped_count = r_clipped;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_pixel_plot_queue.sv
// Self-checking bench for pixel_plot_queue: directed table, corner sequences, random draws
// against a queue-based reference model, and a full Reuleaux drawer stream.
module tb_pixel_plot_queue;
    localparam int     DEPTH = 16;
    localparam longint CMAX  = 65535;
    localparam longint SMAX  = 7;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        bit   st;
        bit   pl;
        bit   dd;
        bit   vr;
        pix_t p;
        bit   e_plot;
        pix_t e_pix;
        int   e_plotted;
        int   e_clipped;
        bit   e_done;
    } vec_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic [7:0] in_x      = 8'd0;
    logic [6:0] in_y      = 7'd0;
    logic [2:0] in_colour = 3'd0;
    logic       in_plot   = 1'b0;
    logic       draw_done = 1'b0;
    logic       vga_ready = 1'b0;

    logic        in_ready, vga_plot, done, overflow;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic [15:0] plotted_count, clipped_count;

    logic       s_in_ready, s_vga_plot, s_done, s_overflow;
    logic [7:0] s_vga_x;
    logic [6:0] s_vga_y;
    logic [2:0] s_vga_colour;
    logic [2:0] s_plotted, s_clipped;

    int n_checks = 0;
    int n_errors = 0;

    pixel_plot_queue #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .in_plot(in_plot), .in_ready(in_ready),
        .draw_done(draw_done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .vga_ready(vga_ready), .done(done),
        .plotted_count(plotted_count), .clipped_count(clipped_count), .overflow(overflow)
    );

    pixel_plot_queue #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .in_plot(in_plot), .in_ready(s_in_ready),
        .draw_done(draw_done), .vga_x(s_vga_x), .vga_y(s_vga_y), .vga_colour(s_vga_colour),
        .vga_plot(s_vga_plot), .vga_ready(vga_ready), .done(s_done),
        .plotted_count(s_plotted), .clipped_count(s_clipped), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: the FIFO is a plain queue, phase 0..3 = idle/run/flush/done
    pix_t   m_q[$];
    int     m_phase = 0;
    bit     m_plot  = 1'b0;
    pix_t   m_last  = 18'd0;
    longint m_plotted = 0;
    longint m_clipped = 0;
    bit     m_ovf = 1'b0;
    int     m_sz;
    bit     m_acc, m_on, m_pop, m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_phase   = 0;
            m_plot    = 1'b0;
            m_last    = 18'd0;
            m_plotted = 0;
            m_clipped = 0;
            m_ovf     = 1'b0;
        end else begin
            m_sz   = m_q.size();
            m_acc  = in_plot && (m_phase == 1 || m_phase == 2);
            m_on   = (in_x < 8'd160) && (in_y < 7'd120);
            m_pop  = (m_sz > 0) && vga_ready;
            m_push = m_acc && m_on && (m_sz < DEPTH);
            m_plot = m_pop;
            if (m_pop) m_last = m_q.pop_front();
            if (m_push) m_q.push_back({in_x, in_y, in_colour});
            if (m_phase == 0 && start) begin
                m_plotted = 0;
                m_clipped = 0;
                m_ovf     = 1'b0;
            end else begin
                if (m_pop) m_plotted++;
                if (m_acc && !m_on) m_clipped++;
                if (m_acc && m_on && m_sz >= DEPTH) m_ovf = 1'b1;
            end
            case (m_phase)
                0: if (start) m_phase = 1;
                1: if (draw_done) m_phase = 2;
                2: if (m_sz == 0 && !m_push) m_phase = 3;
                3: if (!start) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("vga_plot", vga_plot, m_plot);
            check("vga_pixel", {vga_x, vga_y, vga_colour}, m_last);
            check("in_ready", in_ready, (m_q.size() < DEPTH));
            check("done", done, (m_phase == 3));
            check("plotted_count", plotted_count, sat(m_plotted, CMAX));
            check("clipped_count", clipped_count, sat(m_clipped, CMAX));
            check("overflow", overflow, m_ovf);
            check("plotted_sat3", s_plotted, sat(m_plotted, SMAX));
            check("clipped_sat3", s_clipped, sat(m_clipped, SMAX));
            check("small_inst_misc",
                  {s_vga_plot, s_vga_x, s_vga_y, s_vga_colour, s_done, s_overflow, s_in_ready},
                  {m_plot, m_last, (m_phase == 3), m_ovf, (m_q.size() < DEPTH)});
        end
    end

    pix_t got[$];

    // Record every pixel issued to the adapter
    always @(negedge clk) begin
        if (rst_n && vga_plot) got.push_back({vga_x, vga_y, vga_colour});
    end

    task automatic drive(input bit st, input bit pl, input bit dd, input bit vr, input pix_t p);
        @(negedge clk);
        start     = st;
        in_plot   = pl;
        draw_done = dd;
        vga_ready = vr;
        {in_x, in_y, in_colour} = p;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_draw(input int lim);
        int i;
        i = 0;
        while (!done && i < lim) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 18'd0);
            settle();
            i++;
        end
        check("draw_reaches_done", done, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 18'd0);
        settle();
        check("done_clears", done, 0);
    endtask

    function automatic vec_t mk(input bit st, input bit pl, input bit dd, input bit vr, input pix_t p,
                                input bit e_plot, input pix_t e_pix, input int e_pl, input int e_cl,
                                input bit e_done);
        vec_t v;
        v.st = st; v.pl = pl; v.dd = dd; v.vr = vr; v.p = p;
        v.e_plot = e_plot; v.e_pix = e_pix; v.e_plotted = e_pl; v.e_clipped = e_cl; v.e_done = e_done;
        return v;
    endfunction

    pix_t pts[$];
    pix_t exp_q[$];

    task automatic gen_reuleaux();
        int  kx[3];
        int  ky[3];
        int  x, y, d, px, py, ox, oy, dx, dy;
        bit  keep;
        kx = '{120, 40, 80};
        ky = '{83, 83, 14};
        pts.delete();
        for (int k = 0; k < 3; k++) begin
            x = 0;
            y = 80;
            d = 3 - 2 * 80;
            while (y >= x) begin
                for (int o = 0; o < 8; o++) begin
                    case (o)
                        0: begin ox = x;  oy = y;  end
                        1: begin ox = y;  oy = x;  end
                        2: begin ox = -x; oy = y;  end
                        3: begin ox = -y; oy = x;  end
                        4: begin ox = x;  oy = -y; end
                        5: begin ox = y;  oy = -x; end
                        6: begin ox = -x; oy = -y; end
                        default: begin ox = -y; oy = -x; end
                    endcase
                    px = kx[k] + ox;
                    py = ky[k] + oy;
                    keep = (px >= 0) && (px < 256) && (py >= 0) && (py < 128);
                    for (int j = 0; j < 3; j++) begin
                        if (j != k) begin
                            dx = px - kx[j];
                            dy = py - ky[j];
                            if (dx * dx + dy * dy > 80 * 80 + 80) keep = 1'b0;
                        end
                    end
                    if (keep) pts.push_back({px[7:0], py[6:0], 3'(k + 1)});
                end
                if (d < 0) begin
                    d = d + 4 * x + 6;
                end else begin
                    d = d + 4 * (x - y) + 10;
                    y--;
                end
                x++;
            end
        end
    endtask

    vec_t tv[14];
    pix_t p3[17];
    pix_t p1, rp;
    int   pr;
    bit   seen;
    int   n_got;

    initial begin
        p1 = {8'd10, 7'd20, 3'd3};
        tv[0]  = mk(1, 0, 0, 1, 18'd0,               0, 18'd0, 0, 0, 0);
        tv[1]  = mk(1, 1, 0, 1, p1,                  0, 18'd0, 0, 0, 0);
        tv[2]  = mk(1, 0, 0, 1, 18'd0,               1, p1,    1, 0, 0);
        tv[3]  = mk(1, 0, 0, 1, 18'd0,               0, p1,    1, 0, 0);
        tv[4]  = mk(1, 1, 0, 1, {8'd160, 7'd5, 3'd1}, 0, p1,   1, 1, 0);
        tv[5]  = mk(1, 1, 0, 1, {8'd5, 7'd120, 3'd2}, 0, p1,   1, 2, 0);
        tv[6]  = mk(1, 0, 0, 1, 18'd0,               0, p1,    1, 2, 0);
        tv[7]  = mk(1, 0, 1, 1, 18'd0,               0, p1,    1, 2, 0);
        tv[8]  = mk(1, 0, 1, 1, 18'd0,               0, p1,    1, 2, 1);
        tv[9]  = mk(0, 0, 0, 1, 18'd0,               0, p1,    1, 2, 0);
        tv[10] = mk(1, 0, 0, 1, 18'd0,               0, p1,    0, 0, 0);
        tv[11] = mk(1, 0, 1, 1, 18'd0,               0, p1,    0, 0, 0);
        tv[12] = mk(1, 0, 1, 1, 18'd0,               0, p1,    0, 0, 1);
        tv[13] = mk(0, 0, 0, 1, 18'd0,               0, p1,    0, 0, 0);

        // Reset state
        #12;
        check("rst_outputs", {vga_plot, vga_x, vga_y, vga_colour, done, overflow}, 0);
        check("rst_counts", {plotted_count, clipped_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic push/pop, clipping and draw sequencing
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].st, tv[i].pl, tv[i].dd, tv[i].vr, tv[i].p);
            settle();
            check($sformatf("tv%0d_plot", i), vga_plot, tv[i].e_plot);
            check($sformatf("tv%0d_pix", i), {vga_x, vga_y, vga_colour}, tv[i].e_pix);
            check($sformatf("tv%0d_plotted", i), plotted_count, tv[i].e_plotted);
            check($sformatf("tv%0d_clipped", i), clipped_count, tv[i].e_clipped);
            check($sformatf("tv%0d_done", i), done, tv[i].e_done);
            check($sformatf("tv%0d_ready", i), in_ready, 1);
        end

        // Fill to full with the adapter stalled, then drain in order
        drive(1, 0, 0, 0, 18'd0);
        settle();
        got.delete();
        for (int i = 0; i < 17; i++) begin
            p3[i] = {8'(i * 9), 7'(i * 3 + 1), 3'(i)};
            drive(1, 1, 0, 0, p3[i]);
            settle();
            if (i == 14) check("ready_before_full", in_ready, 1);
            if (i == 15) check("ready_when_full", in_ready, 0);
            if (i == 16) check("overflow_set", overflow, 1);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 1, 18'd0);
            settle();
        end
        check("drain_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check($sformatf("drain_order%0d", i), got[i], p3[i]);
        finish_draw(40);

        // done waits for the last queued pixel under an alternating vga_ready
        drive(1, 0, 0, 0, 18'd0);
        settle();
        got.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, {8'(30 + i), 7'(40 + i), 3'(i + 4)});
            settle();
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            drive(1, 0, 1, (i % 2 == 0), 18'd0);
            settle();
            if (done) begin
                seen = 1'b1;
                check("done_after_3rd_plot", got.size(), 3);
            end
        end
        check("done_seen", seen, 1);
        drive(0, 0, 0, 1, 18'd0);
        settle();
        check("done_drops", done, 0);
        n_got = got.size();
        drive(0, 1, 0, 1, {8'd7, 7'd7, 3'd7});
        settle();
        drive(0, 0, 0, 1, 18'd0);
        settle();
        check("idle_ignores_plot", got.size(), n_got);

        // Asynchronous reset in the middle of a drain
        drive(1, 0, 0, 0, 18'd0);
        settle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, {8'(50 + i), 7'(60 + i), 3'(i)});
            settle();
        end
        drive(1, 0, 0, 1, 18'd0);
        settle();
        check("pre_reset_plot", vga_plot, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {vga_plot, vga_x, vga_y, vga_colour, done, overflow}, 0);
        check("midrst_counts", {plotted_count, clipped_count}, 0);
        @(negedge clk);
        start = 1'b0; in_plot = 1'b0; draw_done = 1'b0; vga_ready = 1'b1;
        got.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 18'd0);
            settle();
            check("post_rst_ready", in_ready, 1);
        end
        check("post_rst_no_plot", got.size(), 0);

        // Random draws, every cycle checked against the model
        for (int d = 0; d < 6; d++) begin
            pr = (d % 2 == 0) ? 80 : 15;
            drive(1, 0, 0, 1, 18'd0);
            settle();
            for (int c = 0; c < 80; c++) begin
                rp = {8'($urandom_range(199, 0)), 7'($urandom_range(127, 0)), 3'($urandom_range(7, 0))};
                drive(1, ($urandom_range(99, 0) < 70), (c == 79), ($urandom_range(99, 0) < pr), rp);
                settle();
            end
            for (int c = 0; c < 5; c++) begin
                rp = {8'($urandom_range(199, 0)), 7'($urandom_range(127, 0)), 3'($urandom_range(7, 0))};
                drive(1, ($urandom_range(99, 0) < 70), 0, ($urandom_range(99, 0) < 50), rp);
                settle();
            end
            finish_draw(200);
        end

        // Full Reuleaux drawer stream
        gen_reuleaux();
        exp_q.delete();
        foreach (pts[i]) if (pts[i].x < 8'd160 && pts[i].y < 7'd120) exp_q.push_back(pts[i]);
        drive(1, 0, 0, 1, 18'd0);
        settle();
        got.delete();
        foreach (pts[i]) begin
            drive(1, 1, 0, 1, pts[i]);
            settle();
        end
        finish_draw(100);
        check("reuleaux_len", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            if (got[i] !== exp_q[i]) check($sformatf("reuleaux_pix%0d", i), got[i], exp_q[i]);
        end
        check("reuleaux_total", plotted_count + clipped_count, pts.size());
        check("reuleaux_plotted", plotted_count, exp_q.size());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
